// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised modulo up/down counter with load, saturate mode, terminal count and sticky wrap flag
module mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MAX      = 7,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             at_top;
    logic             at_bottom;

    assign at_top       = (out == MAX_V);
    assign at_bottom    = (out == ZERO_V);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // tc doubles as the bound-event qualifier: the next edge wraps or saturates
    assign tc = en & ~load & (up ? at_top : at_bottom);

    always_comb begin
        count_next = out;
        if (up) begin
            if (!at_top) begin
                count_next = out + ONE_V;
            end else begin
                count_next = SATURATE ? MAX_V : ZERO_V;
            end
        end else begin
            if (!at_bottom) begin
                count_next = out - ONE_V;
            end else begin
                count_next = SATURATE ? ZERO_V : MAX_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out     <= ZERO_V;
            wrapped <= 1'b0;
        end else begin
            if (load) begin
                out <= load_clamped;
            end else if (en) begin
                out <= count_next;
            end
            // a coincident bound event beats the clear
            if (tc) begin
                wrapped <= 1'b1;
            end else if (clr_flag) begin
                wrapped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter across three parameter sets
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_flag;
    logic [3:0] load_val;
    logic [2:0] q0, q2;
    logic [3:0] q1;
    logic       tc0, tc1, tc2, wr0, wr1, wr2;

    always #5 clk = ~clk;

    mod_counter u_def (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .clr_flag(clr_flag),
        .out(q0), .tc(tc0), .wrapped(wr0)
    );

    mod_counter #(.WIDTH(4), .MAX(5), .SATURATE(1'b0)) u_m5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_flag(clr_flag),
        .out(q1), .tc(tc1), .wrapped(wr1)
    );

    mod_counter #(.WIDTH(3), .MAX(7), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .clr_flag(clr_flag),
        .out(q2), .tc(tc2), .wrapped(wr2)
    );

    typedef struct {
        bit       rst, en, up, load, clr;
        bit [3:0] lv;
        bit       tc;
        int       q;
        bit       wr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int mx[3]  = '{7, 5, 7};
    bit sat[3] = '{1'b0, 1'b0, 1'b1};
    int m_q[3] = '{0, 0, 0};
    bit m_wr[3] = '{1'b0, 1'b0, 1'b0};
    vec_t tbl[22];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_q(input int i);
        case (i)
            0: return int'(q0);
            1: return int'(q1);
            default: return int'(q2);
        endcase
    endfunction

    function automatic int dut_tc(input int i);
        case (i)
            0: return int'(tc0);
            1: return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int dut_wr(input int i);
        case (i)
            0: return int'(wr0);
            1: return int'(wr1);
            default: return int'(wr2);
        endcase
    endfunction

    function automatic bit model_tc(input int i);
        return en && !load && (up ? (m_q[i] == mx[i]) : (m_q[i] == 0));
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int lv;
            bit bev;
            lv  = (i == 1) ? int'(load_val) : int'(load_val) % 8;
            bev = model_tc(i);
            if (!rst) begin
                m_q[i]  = 0;
                m_wr[i] = 1'b0;
            end else begin
                if (load) begin
                    m_q[i] = (lv > mx[i]) ? mx[i] : lv;
                end else if (en) begin
                    if (sat[i])
                        m_q[i] = up ? ((m_q[i] < mx[i]) ? m_q[i] + 1 : mx[i])
                                    : ((m_q[i] > 0) ? m_q[i] - 1 : 0);
                    else
                        m_q[i] = up ? (m_q[i] + 1) % (mx[i] + 1)
                                    : (m_q[i] + mx[i]) % (mx[i] + 1);
                end
                if (bev) m_wr[i] = 1'b1;
                else if (clr_flag) m_wr[i] = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input bit c, input bit [3:0] v);
        rst = r; en = e; up = u; load = l; clr_flag = c; load_val = v;
    endtask

    // called one time unit after a rising edge; inputs already driven
    task automatic step();
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("model_tc[%0d]", i), dut_tc(i), int'(model_tc(i)));
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_out[%0d]", i), dut_q(i), m_q[i]);
            check($sformatf("model_wrapped[%0d]", i), dut_wr(i), int'(m_wr[i]));
        end
    endtask

    initial begin
        tbl[0]  = '{0,0,1,0,0,4'd0, 0,0,0};
        tbl[1]  = '{0,0,1,0,0,4'd0, 0,0,0};
        tbl[2]  = '{1,1,1,0,0,4'd0, 0,1,0};
        tbl[3]  = '{1,1,1,0,0,4'd0, 0,2,0};
        tbl[4]  = '{1,1,1,0,0,4'd0, 0,3,0};
        tbl[5]  = '{1,1,1,0,0,4'd0, 0,4,0};
        tbl[6]  = '{1,1,1,0,0,4'd0, 0,5,0};
        tbl[7]  = '{1,1,1,0,0,4'd0, 0,6,0};
        tbl[8]  = '{1,1,1,0,0,4'd0, 0,7,0};
        tbl[9]  = '{1,1,1,0,0,4'd0, 1,0,1};
        tbl[10] = '{1,1,1,0,0,4'd0, 0,1,1};
        tbl[11] = '{1,1,1,0,0,4'd0, 0,2,1};
        tbl[12] = '{0,0,1,0,0,4'd0, 0,0,0};
        tbl[13] = '{1,1,0,0,0,4'd0, 1,7,1};
        tbl[14] = '{1,1,0,0,0,4'd0, 0,6,1};
        tbl[15] = '{1,1,1,1,0,4'd4, 0,4,1};
        tbl[16] = '{0,1,1,1,0,4'd6, 0,0,0};
        tbl[17] = '{1,1,1,1,0,4'd7, 0,7,0};
        tbl[18] = '{1,1,1,0,1,4'd0, 1,0,1};
        tbl[19] = '{1,0,1,0,1,4'd0, 0,0,0};
        tbl[20] = '{1,0,1,0,0,4'd0, 0,0,0};
        tbl[21] = '{1,1,0,0,1,4'd0, 1,7,1};

        drive(0, 0, 1, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        check("reset_out_def", int'(q0), 0);
        check("reset_out_m5", int'(q1), 0);
        check("reset_wrapped_def", int'(wr0), 0);
        check("reset_tc_def", int'(tc0), 0);

        for (int k = 0; k < 22; k++) begin
            drive(tbl[k].rst, tbl[k].en, tbl[k].up, tbl[k].load, tbl[k].clr, tbl[k].lv);
            #1;
            check($sformatf("tbl%0d_tc", k), int'(tc0), int'(tbl[k].tc));
            step();
            check($sformatf("tbl%0d_out", k), int'(q0), tbl[k].q);
            check($sformatf("tbl%0d_wrapped", k), int'(wr0), int'(tbl[k].wr));
        end

        // clamped load on the MAX=5 instance, then load beats count
        begin
            int wr_before;
            wr_before = int'(wr1);
            drive(1, 1, 1, 1, 0, 4'd9);
            step();
            check("m5_clamp_out", int'(q1), 5);
            check("m5_clamp_wrapped", int'(wr1), wr_before);
            drive(1, 1, 1, 1, 0, 4'd2);
            step();
            check("m5_load_beats_en", int'(q1), 2);
        end

        // saturating instance holds at the top, then reverses
        drive(1, 0, 1, 1, 1, 4'd6);
        step();
        check("sat_load6", int'(q2), 6);
        check("sat_cleared", int'(wr2), 0);
        drive(1, 1, 1, 0, 0, 4'd0);
        step();
        check("sat_out_a", int'(q2), 7);
        check("sat_wrapped_a", int'(wr2), 0);
        check("sat_tc_at_max", int'(tc2), 1);
        step();
        check("sat_out_b", int'(q2), 7);
        check("sat_wrapped_b", int'(wr2), 1);
        step();
        check("sat_out_c", int'(q2), 7);
        drive(1, 1, 0, 0, 0, 4'd0);
        step();
        check("sat_down", int'(q2), 6);

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 32) != 0, ($urandom % 4) != 0, 1'($urandom % 2),
                  ($urandom % 8) == 0, ($urandom % 8) == 0, 4'($urandom % 16));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
